// File: rtl/transmission_pkg.sv
// Shared types and constants for the 8-channel time-division transmission scheduler.
package transmission_pkg;
  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {IDLE, ARB, HOLD, SAMPLE} sched_state_t;

  localparam logic LINK_IDLE = 1'b1;
endpackage

// File: rtl/rr_arbiter8.sv
// Combinational round-robin pick: first requester after last_ch, wrapping modulo 8.
module rr_arbiter8
  import transmission_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] last_ch,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_vld
);

  // Walk offsets from farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    logic [SEL_W-1:0] idx;
    idx       = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = NCH; i >= 1; i--) begin
      idx = last_ch + SEL_W'(i);
      if (req[idx]) begin
        grant_idx = idx;
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/transmission_scheduler.sv
// Round-robin slot scheduler driving the datapath select lines and capturing the returned bit per channel.
module transmission_scheduler
  import transmission_pkg::*;
#(
  parameter int SLOT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   link_o,
  output logic             sel_a,
  output logic             sel_b,
  output logic             sel_c,
  output logic [SEL_W-1:0] cur_ch,
  output logic             busy,
  output logic [NCH-1:0]   rx_data,
  output logic [NCH-1:0]   rx_valid,
  output logic             slot_done
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SLOT_CYCLES - 2);

  sched_state_t     state, nxt;
  logic [SEL_W-1:0] sel, last_ch, grant_idx;
  logic [CW-1:0]    cnt;
  logic             grant_vld, sample_fire;

  rr_arbiter8 u_arb (
    .req       (req),
    .last_ch   (last_ch),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (en && |req) nxt = ARB;
      ARB:     nxt = grant_vld ? HOLD : IDLE;
      HOLD:    if (cnt == '0) nxt = SAMPLE;
      SAMPLE:  nxt = (en && |req) ? ARB : IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign sample_fire = (state == SAMPLE);

  // last_ch resets to 7 so the very first search begins at channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel       <= '0;
      last_ch   <= SEL_W'(NCH - 1);
      cnt       <= '0;
      slot_done <= 1'b0;
    end else begin
      slot_done <= sample_fire;
      if (state == ARB && grant_vld) begin
        sel <= grant_idx;
        cnt <= CNT_LOAD;
      end else if (state == HOLD && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (sample_fire) last_ch <= sel;
    end
  end

  // Per-channel receive bit and strobe; only the selected channel ever updates.
  for (genvar k = 0; k < NCH; k++) begin : g_rx
    logic hit;
    assign hit = sample_fire && (sel == SEL_W'(k));
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rx_data[k]  <= LINK_IDLE;
        rx_valid[k] <= 1'b0;
      end else begin
        rx_valid[k] <= hit;
        if (hit) rx_data[k] <= link_o[k];
      end
    end
  end

  assign sel_a  = sel[2];
  assign sel_b  = sel[1];
  assign sel_c  = sel[0];
  assign cur_ch = sel;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_transmission_scheduler.sv
// Scheduler plus a behavioural datapath, checked cycle by cycle against a slot-timing reference model.
module tb_transmission_scheduler;
  localparam int SLOT = 4;

  logic       clk = 1'b0, rst, en;
  logic [7:0] req, link_o, idata, rx_data, rx_valid;
  logic [2:0] cur_ch, dsel;
  logic       sel_a, sel_b, sel_c, busy, slot_done;

  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [7:0] data_and = 8'hFF;

  // reference model: phase -1 idle, 0 arbitration, 1..SLOT-1 hold, SLOT sample
  int         m_phase;
  logic [2:0] m_sel, m_last;
  logic [7:0] m_rxd, m_rxv;
  logic       m_sd;

  int gq[$];
  int tq[$];

  transmission_scheduler #(.SLOT_CYCLES(SLOT)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .link_o(link_o),
    .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c), .cur_ch(cur_ch), .busy(busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .slot_done(slot_done)
  );

  always #5 clk = ~clk;

  // mux on iData[sel], demux onto oData; unselected lines idle high
  assign dsel = {sel_a, sel_b, sel_c};
  always_comb begin
    link_o       = 8'hFF;
    link_o[dsel] = idata[dsel];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = -1; m_sel = 3'd0; m_last = 3'd7;
    m_rxd = 8'hFF; m_rxv = 8'h00; m_sd = 1'b0;
  endtask

  task automatic m_edge(input logic e, input logic [7:0] r, input logic [7:0] d);
    m_rxv = 8'h00; m_sd = 1'b0;
    if (m_phase < 0) begin
      if (e && r != 0) m_phase = 0;
    end else if (m_phase == 0) begin
      if (r == 0) m_phase = -1;
      else begin
        for (int i = 8; i >= 1; i--)
          if (r[(m_last + i) % 8]) m_sel = 3'((m_last + i) % 8);
        m_phase = 1;
      end
    end else if (m_phase < SLOT) begin
      m_phase++;
    end else begin
      m_rxd[m_sel] = d[m_sel];
      m_rxv = 8'h01 << m_sel;
      m_sd = 1'b1;
      m_last = m_sel;
      m_phase = (e && r != 0) ? 0 : -1;
    end
  endtask

  task automatic check_all();
    chk("sel",       {29'd0, sel_a, sel_b, sel_c}, {29'd0, m_sel});
    chk("cur_ch",    {29'd0, cur_ch}, {29'd0, m_sel});
    chk("busy",      {31'd0, busy}, {31'd0, m_phase >= 0});
    chk("rx_valid",  {24'd0, rx_valid}, {24'd0, m_rxv});
    chk("slot_done", {31'd0, slot_done}, {31'd0, m_sd});
    chk("rx_data",   {24'd0, rx_data}, {24'd0, m_rxd});
  endtask

  task automatic step();
    logic e; logic [7:0] r, d;
    e = en; r = req; d = idata;
    @(posedge clk);
    m_edge(e, r, d);
    #1;
    cyc++;
    check_all();
    if (rx_valid != 0) begin gq.push_back(int'(cur_ch)); tq.push_back(cyc); end
    idata = 8'($urandom) & data_and;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    gq.delete(); tq.delete();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_hold(input logic [2:0] ch, input string tag);
    int found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step();
      if (m_phase == 1 && m_sel == ch) found = 1;
    end
    chk(tag, found, 1);
  endtask

  task automatic chk_grants(input string tag, input int exp[]);
    chk({tag, "_count_ge"}, gq.size() >= exp.size(), 1);
    for (int i = 0; i < exp.size() && i < gq.size(); i++)
      chk(tag, gq[i], exp[i]);
  endtask

  task automatic chk_period(input string tag, input int n);
    for (int i = 1; i < n && i < tq.size(); i++)
      chk(tag, tq[i] - tq[i-1], SLOT + 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 8'h00; idata = 8'h00;
    m_reset();
    // 1. reset state
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // 2. single requester ch5, source bit held low
    en = 1'b1; req = 8'h20; data_and = 8'hDF; idata = 8'h00;
    run(17);
    chk_grants("s2_grant", '{5, 5, 5});
    chk_period("s2_period", 3);
    chk("s2_first_lat", tq.size() > 0 ? tq[0] : -1, 2 + SLOT);
    chk("s2_rx5", {31'd0, rx_data[5]}, 0);

    // 1b. reset asserted mid-HOLD, checked without a clock edge
    for (int i = 0; i < 10 && m_phase != 2; i++) step();
    chk("s1_in_hold", m_phase, 2);
    rst = 1'b1;
    #1;
    chk("rst_rx_data",  {24'd0, rx_data}, 32'hFF);
    chk("rst_sel",      {29'd0, cur_ch}, 0);
    chk("rst_busy",     {31'd0, busy}, 0);
    chk("rst_rx_valid", {24'd0, rx_valid}, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    gq.delete(); tq.delete();

    // 3. three requesters, toggling source data
    data_and = 8'hFF; en = 1'b1; req = 8'b1000_0101;
    run(33);
    chk_grants("s3_grant", '{0, 2, 7, 0, 2, 7});

    // 4. all channels requesting: strict rotation from channel 0
    do_reset();
    en = 1'b1; req = 8'hFF;
    run(48);
    chk_grants("s4_grant", '{0, 1, 2, 3, 4, 5, 6, 7, 0});
    chk_period("s4_period", 9);

    // 5. enable dropped during HOLD of ch3
    do_reset();
    en = 1'b1; req = 8'h08;
    wait_hold(3'd3, "s5_reach_hold");
    en = 1'b0;
    run(10);
    chk_grants("s5_grant", '{3});
    chk("s5_count", gq.size(), 1);
    chk("s5_busy", {31'd0, busy}, 0);
    chk("s5_sel_idle", {29'd0, cur_ch}, 3);

    // 6. drop req[3] mid-slot, then ch6, then idle
    do_reset();
    en = 1'b1; req = 8'h48;
    wait_hold(3'd3, "s6_reach_hold3");
    req = 8'h40;
    wait_hold(3'd6, "s6_reach_hold6");
    req = 8'h00;
    run(10);
    chk_grants("s6_grant", '{3, 6});
    chk("s6_count", gq.size(), 2);
    chk("s6_busy", {31'd0, busy}, 0);

    // 7. randomized traffic with occasional mid-run resets
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 149) == 0) do_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
